// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory port.
// Byte-enable, alignment and store-lane replication for a 4-byte word.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  function automatic logic [3:0] calc_be(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (size == SZ_B): be = 4'b0001 << off;
      (size == SZ_H): be = 4'b0011 << off;
      default:        be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == SZ_R)
      | ((size == SZ_H) & off[0])
      | ((size == SZ_W) & (off != 2'b00));
  endfunction

  function automatic logic [31:0] replicate(
    input logic [1:0]  size,
    input logic [31:0] wdata
  );
    logic [31:0] d;
    d = wdata;
    unique case (1'b1)
      (size == SZ_B): d = {4{wdata[7:0]}};
      (size == SZ_H): d = {2{wdata[15:0]}};
      default:        d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts a byte/half/word from a memory word at a byte offset
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  logic        sb;
  logic        shh;

  assign sh  = word_i >> {off_i, 3'b000};
  assign sb  = ~unsigned_i & sh[7];
  assign shh = ~unsigned_i & sh[15];

  always_comb begin
    data_o = sh;
    unique case (1'b1)
      (size_i == SZ_B): data_o = {{24{sb}}, sh[7:0]};
      (size_i == SZ_H): data_o = {{16{shh}}, sh[15:0]};
      default:          data_o = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store front end for a 1-cycle registered-read data memory:
// one request pending in memory, one response held at the output.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int BYTES         = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [TAG_WIDTH-1:0]     rsp_tag,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [BYTES-1:0]         mem_be,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     mem_we,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  logic                     p_v_q;
  logic                     p_we_q;
  logic [1:0]               p_off_q;
  logic [1:0]               p_size_q;
  logic                     p_uns_q;
  logic [TAG_WIDTH-1:0]     p_tag_q;
  logic                     p_err_q;
  logic [ADDRESS_WIDTH-1:0] p_waddr_q;

  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic [TAG_WIDTH-1:0]     rsp_tag_q;
  logic                     rsp_err_q;

  logic                     advance;
  logic [1:0]               req_off;
  logic                     req_err;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic [DATA_WIDTH-1:0]    rsp_rdata_d;

  assign advance   = ~rsp_valid_q | rsp_ready;
  assign req_ready = advance;
  assign req_off   = req_addr[1:0];
  assign req_err   = misaligned(req_size, req_off);

  // Re-present the pending word during a stall so read data stays put.
  assign mem_addr = advance ? req_addr[ADDRESS_WIDTH+1:2]
                            : p_waddr_q;
  assign mem_we = req_valid & advance & req_we & ~req_err & rst_n;
  assign mem_be = mem_we ? calc_be(req_size, req_off) : '0;
  assign mem_data_in = replicate(req_size, req_wdata);

  lsu_load_align u_align (
    .word_i     (mem_data_out),
    .off_i      (p_off_q),
    .size_i     (p_size_q),
    .unsigned_i (p_uns_q),
    .data_o     (ld_data)
  );

  assign rsp_rdata_d = (p_v_q & ~p_we_q & ~p_err_q) ? ld_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v_q       <= 1'b0;
      p_we_q      <= 1'b0;
      p_off_q     <= '0;
      p_size_q    <= '0;
      p_uns_q     <= 1'b0;
      p_tag_q     <= '0;
      p_err_q     <= 1'b0;
      p_waddr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else if (advance) begin
      p_v_q       <= req_valid;
      p_we_q      <= req_we;
      p_off_q     <= req_off;
      p_size_q    <= req_size;
      p_uns_q     <= req_unsigned;
      p_tag_q     <= req_tag;
      p_err_q     <= req_err;
      p_waddr_q   <= req_addr[ADDRESS_WIDTH+1:2];
      rsp_valid_q <= p_v_q;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_tag_q   <= p_tag_q;
      rsp_err_q   <= p_v_q & p_err_q;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a byte-enabled memory model.
// Table of per-cycle stimulus plus stall and reset sequences.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [13:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_tag;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .req_tag      (req_tag),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_tag      (rsp_tag),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          mem[mem_addr][b*8 +: 8] <= mem_data_in[b*8 +: 8];
    mem_data_out <= mem[mem_addr];
  end

  typedef struct {
    logic        v;
    logic        we;
    logic [13:0] addr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wd;
    logic [4:0]  tag;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_din;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [4:0]  e_tag;
    logic        e_err;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic [13:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       input logic [4:0] tag);
    req_valid    = v;
    req_we       = we;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
    req_tag      = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 32'h0;

    tv[0]  = '{1'b1, 1'b1, 14'h010, SZ_W, 1'b0, 32'h11223344, 5'd1,
               1'b1, 4'b1111, 32'h11223344, 1'b0, 32'h0, 5'd0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 14'h013, SZ_B, 1'b0, 32'h0, 5'd2,
               1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 14'h012, SZ_B, 1'b0, 32'h00000080, 5'd3,
               1'b1, 4'b0100, 32'h80808080, 1'b1, 32'h0, 5'd1, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 14'h012, SZ_B, 1'b0, 32'h0, 5'd4,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h00000011, 5'd2, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 14'h012, SZ_B, 1'b1, 32'h0, 5'd5,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 5'd3, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 14'h012, SZ_H, 1'b0, 32'h0, 5'd6,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFFFF80, 5'd4, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 14'h011, SZ_H, 1'b0, 32'h0, 5'd7,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h00000080, 5'd5, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 14'h012, SZ_W, 1'b0, 32'hDEADBEEF, 5'd8,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h00001180, 5'd6, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 14'h020, SZ_R, 1'b0, 32'h0, 5'd9,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 5'd7, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 14'h010, SZ_W, 1'b0, 32'h0, 5'd10,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 5'd8, 1'b1};
    tv[10] = '{1'b1, 1'b1, 14'h022, SZ_H, 1'b0, 32'h00008001, 5'd11,
               1'b1, 4'b1100, 32'h80018001, 1'b1, 32'h0, 5'd9, 1'b1};
    tv[11] = '{1'b1, 1'b0, 14'h022, SZ_H, 1'b0, 32'h0, 5'd12,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h11803344, 5'd10, 1'b0};
    tv[12] = '{1'b1, 1'b0, 14'h022, SZ_H, 1'b1, 32'h0, 5'd13,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 5'd11, 1'b0};
    tv[13] = '{1'b0, 1'b0, 14'h000, SZ_W, 1'b0, 32'h0, 5'd0,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF8001, 5'd12, 1'b0};
    tv[14] = '{1'b0, 1'b0, 14'h000, SZ_W, 1'b0, 32'h0, 5'd0,
               1'b0, 4'b0000, 32'h0, 1'b1, 32'h00008001, 5'd13, 1'b0};
    tv[15] = '{1'b0, 1'b0, 14'h000, SZ_W, 1'b0, 32'h0, 5'd0,
               1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0};

    // Reset with a store presented: no write, outputs cleared.
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 14'h010, SZ_W, 1'b0, 32'hFFFFFFFF, 5'd31);
    tick();
    tick();
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 16; i++) begin
      drive(tv[i].v, tv[i].we, tv[i].addr, tv[i].sz,
            tv[i].uns, tv[i].wd, tv[i].tag);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'h1);
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tv[i].e_we));
      chk($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(tv[i].e_be));
      if (tv[i].v)
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr),
            32'(tv[i].addr[13:2]));
      if (tv[i].e_we)
        chk($sformatf("v%0d_mem_din", i), mem_data_in, tv[i].e_din);
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid),
          32'(tv[i].e_rv));
      if (tv[i].e_rv) begin
        chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, tv[i].e_rd);
        chk($sformatf("v%0d_rsp_tag", i), 32'(rsp_tag),
            32'(tv[i].e_tag));
        chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err),
            32'(tv[i].e_err));
      end
      tick();
    end

    // Two loads in flight, consumer stalls for three cycles.
    drive(1'b1, 1'b0, 14'h010, SZ_W, 1'b0, 32'h0, 5'd20);
    tick();
    drive(1'b1, 1'b0, 14'h023, SZ_B, 1'b1, 32'h0, 5'd21);
    tick();
    drive(1'b1, 1'b1, 14'h014, SZ_W, 1'b0, 32'hCAFEF00D, 5'd22);
    rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("st%0d_req_ready", s), 32'(req_ready), 32'h0);
      chk($sformatf("st%0d_mem_addr", s), 32'(mem_addr), 32'h8);
      chk($sformatf("st%0d_mem_we", s), 32'(mem_we), 32'h0);
      chk($sformatf("st%0d_rsp_valid", s), 32'(rsp_valid), 32'h1);
      chk($sformatf("st%0d_rsp_tag", s), 32'(rsp_tag), 32'd20);
      chk($sformatf("st%0d_rsp_rdata", s), rsp_rdata, 32'h11803344);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("st_rel_req_ready", 32'(req_ready), 32'h1);
    tick();
    chk("st_b_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("st_b_rsp_tag", 32'(rsp_tag), 32'd21);
    chk("st_b_rsp_rdata", rsp_rdata, 32'h00000080);
    chk("st_b_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    chk("st_drain_valid", 32'(rsp_valid), 32'h0);

    // Reset asserted while a response is held and a load is pending.
    drive(1'b1, 1'b0, 14'h010, SZ_W, 1'b0, 32'h0, 5'd24);
    tick();
    drive(1'b1, 1'b0, 14'h022, SZ_H, 1'b0, 32'h0, 5'd25);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("rs_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rs_rsp_tag", 32'(rsp_tag), 32'd24);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_clr_valid", 32'(rsp_valid), 32'h0);
    chk("rs_clr_tag", 32'(rsp_tag), 32'h0);
    chk("rs_clr_rdata", rsp_rdata, 32'h0);
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("rs_post%0d_valid", r), 32'(rsp_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
